// File: rtl/rf_port_ctrl.sv
// Register-file write-port arbiter: round-robin grant among writeback sources,
// one registered write stage, and read bypass of the in-flight write.
module rf_port_ctrl #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*5-1:0]    req_addr_i,
  input  logic [N_REQ*XLEN-1:0] req_data_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  input  logic [4:0]            rd_addr1_i,
  input  logic [4:0]            rd_addr2_i,
  input  logic [XLEN-1:0]       rf_rdata1_i,
  input  logic [XLEN-1:0]       rf_rdata2_i,
  output logic [XLEN-1:0]       rd_data1_o,
  output logic [XLEN-1:0]       rd_data2_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]   ptr, ptr_next;
  logic [4:0]      addr [N_REQ];
  logic [XLEN-1:0] data [N_REQ];
  logic [N_REQ-1:0] cand, zack, gnt;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr[gi] = req_addr_i[5*gi +: 5];
      assign data[gi] = req_data_i[XLEN*gi +: XLEN];
      assign cand[gi] = req_valid_i[gi] && (addr[gi] != 5'd0);
      assign zack[gi] = req_valid_i[gi] && (addr[gi] == 5'd0);
    end
  endgenerate

  // Scan from ptr, wrapping once; the first nonzero-address requester wins.
  always_comb begin
    int j;
    j        = 0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int off = 0; off < N_REQ; off++) begin
      j = int'(ptr) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_any && cand[j]) begin
        gnt_any  = 1'b1;
        gnt[j]   = 1'b1;
        gnt_idx  = PW'(j);
        sel_addr = addr[j];
        sel_data = data[j];
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (gnt_any) begin
      if (gnt_idx == PW'(N_REQ - 1)) ptr_next = '0;
      else                           ptr_next = PW'(gnt_idx + 1'b1);
    end
  end

  // x0 writes are acknowledged and dropped alongside the real grant.
  assign req_ready_o = rst_ni ? (gnt | zack) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr        <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      ptr     <= ptr_next;
      rf_we_o <= gnt_any;
      if (gnt_any) begin
        rf_waddr_o <= sel_addr;
        rf_wdata_o <= sel_data;
      end
    end
  end

  always_comb begin
    rd_data1_o = rf_rdata1_i;
    rd_data2_o = rf_rdata2_i;
    if (rd_addr1_i == 5'd0)
      rd_data1_o = '0;
    else if (rf_we_o && rf_waddr_o == rd_addr1_i)
      rd_data1_o = rf_wdata_o;
    if (rd_addr2_i == 5'd0)
      rd_data2_o = '0;
    else if (rf_we_o && rf_waddr_o == rd_addr2_i)
      rd_data2_o = rf_wdata_o;
  end

  assign busy_o = (|req_valid_i) || rf_we_o;

endmodule

// File: doc/rf_port_ctrl.md
# rf_port_ctrl

Write-port arbiter and read-bypass controller for the 32x32 register file (`x0` hard-wired to zero, two combinational read ports, one write port written on the rising clock edge). It shares the single write port between `N_REQ` writeback sources (ALU, LSU load return, CSR/interrupt unit) using round-robin arbitration with a valid/ready handshake. Granted writes pass through one output register. The block forwards that in-flight write onto both read ports so readers never see stale data.

## Interface
Parameters:
- `N_REQ`, default 3: number of writeback requesters; legal range 2..8.
- `XLEN`, default 32: data width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous reset, active-low.
- `req_valid_i`  in  N_REQ  requester i holds a write.
- `req_ready_o`  out  N_REQ  requester i accepted this cycle.
- `req_addr_i`  in  N_REQ*5  packed destination register addresses; requester i occupies bits [5i+4:5i].
- `req_data_i`  in  N_REQ*XLEN  packed write data; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
- `rf_we_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  XLEN  register-file write data.
- `rd_addr1_i`, `rd_addr2_i`  in  5 each  read addresses; also driven to the register file.
- `rf_rdata1_i`, `rf_rdata2_i`  in  XLEN each  raw register-file read data.
- `rd_data1_o`, `rd_data2_o`  out  XLEN each  bypassed read data.
- `busy_o`  out  1  any `req_valid_i` is high, or `rf_we_o` is high.

## Operation
Handshake:
- A transfer occurs when `req_valid_i[i] && req_ready_o[i]`.
- A requester holds valid, addr and data stable until accepted; dropping valid before acceptance is illegal.

Arbitration:
- Round-robin pointer `ptr` ranges 0..N_REQ-1.
- Candidates are requesters with valid high and addr != 0.
- The first candidate scanning i = ptr, ptr+1, … modulo N_REQ wins. At most one candidate is granted per cycle.
- After a grant to requester k, `ptr` becomes (k+1) mod N_REQ. `ptr` is unchanged when there is no grant.

Zero-register writes:
- A requester with valid high and addr == 0 gets `req_ready_o` = 1 in the same cycle, whatever the arbitration result.
- It produces no register-file write and does not move `ptr`.
- Several requesters may be acknowledged in one cycle this way.

Write stage:
- On a grant, the next clock edge loads `rf_we_o`=1, `rf_waddr_o`=addr and `rf_wdata_o`=data.
- Without a grant, `rf_we_o` is loaded with 0. Address and data hold their previous values.

Bypass:
- `rd_dataN_o = rf_wdata_o` when `rf_we_o && rf_waddr_o == rd_addrN_i && rd_addrN_i != 0`.
- Otherwise `rd_dataN_o = rf_rdataN_i`.
- `rd_addrN_i == 0` always yields 0, even if `rf_rdataN_i` is nonzero.

Same-address conflicts:
- Requesters targeting the same register are serialized in grant order.
- The later grant is written later and wins.

## Timing
Reset (`rst_ni` low, asynchronous, effective immediately):
- `ptr` = 0, `rf_we_o` = 0, `rf_waddr_o` = 0, `rf_wdata_o` = 0.
- `req_ready_o` = 0 while `rst_ni` is low; `busy_o` follows its definition.
- Reset in the middle of a grant drops the staged write: `rf_we_o` falls asynchronously and no register-file write occurs. Requesters re-present after reset.

Latency:
- Acceptance in cycle N gives `rf_we_o` high in cycle N+1. The register file commits at the end of N+1 (edge N+1→N+2).
- Back-to-back grants give one write per cycle; throughput is 1 write/cycle.

Combinational paths:
- `req_ready_o` is combinational from `req_valid_i`, `req_addr_i` and `ptr`.
- Bypass is combinational from the read inputs and the write-stage registers.
- There is no path from `req_*` to `rd_data*_o`.

Fairness:
- With all N_REQ requesters continuously valid and nonzero, each is granted exactly once every N_REQ cycles.
- Worst-case wait is N_REQ-1 cycles.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_ni` low 3 cycles, release, all valid low.
  - Required: `rf_we_o` = 0, `rf_waddr_o` = 0, `rf_wdata_o` = 0, `req_ready_o` = 0, `busy_o` = 0.
- Single write plus bypass:
  - Stimulus: req0 addr 5, data 0xDEADBEEF in cycle N; `rd_addr1_i` = 5 and `rf_rdata1_i` = 0x0 in cycle N+1.
  - Required: `req_ready_o` = 3'b001 in N; in N+1 `rf_we_o` = 1, `rf_waddr_o` = 5, `rd_data1_o` = 0xDEADBEEF; `rd_data2_o` with `rd_addr2_i` = 6 equals `rf_rdata2_i`.
- Round-robin fairness:
  - Stimulus: all 3 valid from cycle 0, addrs 1/2/3, data 0x11/0x22/0x33, each requester re-presenting immediately after acceptance.
  - Required: grants 0,1,2,0,1,2 in successive cycles; `rf_waddr_o` sequence 1,2,3,1,2,3 one cycle later.
- `x0` discard:
  - Stimulus: req1 addr 0 and req2 addr 7 valid in the same cycle, `ptr` = 0.
  - Required: `req_ready_o` = 3'b110; next cycle `rf_waddr_o` = 7; `ptr` becomes 0 (after the grant to 2); no write to address 0 ever appears.
- Same-address ordering:
  - Stimulus: req0 and req1 both target addr 9 with data 0xA / 0xB, `ptr` = 1.
  - Required: req1 is written first (0xB), then req0 (0xA); final committed value is 0xA.
- Reset mid-write:
  - Stimulus: grant in cycle N, assert `rst_ni` low during N+1 before the edge.
  - Required: `rf_we_o` drops to 0 immediately, no commit, `ptr` = 0.
